conv_window_sched: RTL and testbench

- Sequencer for the 4x4 multiply-accumulate convolution datapath (16 data + 16 kernel operands, ReLU-clamped 25-bit result).
- Loads a 16-tap kernel over a valid/ready stream, walks a 4x4 window across an IMG_H x IMG_W image in pixel memory (stride 1, valid positions only), and presents each operand set to the datapath.
- Captures each result and emits it with its output coordinates over a valid/ready stream.

---
 rtl/conv_window_sched.sv | 152 +++++++++++++++
 tb/tb_conv_window_sched.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched.sv
// Sequencer for the 4x4 convolution datapath: loads a 16-tap kernel, walks a 4x4
// window across pixel memory and streams each datapath result with its coordinates.
module conv_window_sched #(
  parameter int lenOfInput  = 8,
  parameter int lenOfOutput = 25,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int AW          = $clog2(IMG_W*IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     k_valid,
  input  logic [lenOfInput-1:0]    k_data,
  output logic                     k_ready,
  output logic                     mem_rd,
  output logic [AW-1:0]            mem_addr,
  input  logic [lenOfInput-1:0]    mem_data,
  output logic [16*lenOfInput-1:0] win_flat,
  output logic [16*lenOfInput-1:0] kern_flat,
  input  logic [lenOfOutput-1:0]   conv_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [lenOfOutput-1:0]   out_data,
  output logic [AW-1:0]            out_row,
  output logic [AW-1:0]            out_col
);

  typedef enum logic [2:0] {IDLE, LOAD_K, FETCH, WAIT, CONV, OUT, DONE} state_t;

  localparam logic [AW-1:0] LAST_COL   = AW'(IMG_W - 4);
  localparam logic [AW-1:0] LAST_ROW   = AW'(IMG_H - 4);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(IMG_W);

  state_t                state, state_nxt;
  logic [3:0]            tap_cnt;
  logic [3:0]            fetch_cnt;
  logic [3:0]            cap_idx;
  logic                  cap_valid;
  logic [AW-1:0]         row, col;
  logic [AW-1:0]         row_sel, col_sel;
  logic                  more_cols, more_rows;
  logic [lenOfInput-1:0] win  [16];
  logic [lenOfInput-1:0] kern [16];

  assign more_cols = (col < LAST_COL);
  assign more_rows = (row < LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_K;
      LOAD_K:  if (k_valid && tap_cnt == 4'd15) state_nxt = FETCH;
      FETCH:   if (fetch_cnt == 4'd15) state_nxt = WAIT;
      WAIT:    state_nxt = CONV;
      CONV:    state_nxt = OUT;
      OUT: begin
        if (out_ready) begin
          if (more_cols || more_rows) state_nxt = FETCH;
          else                        state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign k_ready = (state == LOAD_K);
  assign mem_rd  = (state == FETCH);

  // Window element (i,j) sits at (row+i, col+j); fetch_cnt encodes i in [3:2], j in [1:0].
  assign row_sel  = row + AW'(fetch_cnt[3:2]);
  assign col_sel  = col + AW'(fetch_cnt[1:0]);
  assign mem_addr = mem_rd ? (row_sel * ROW_STRIDE + col_sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt   <= '0;
      fetch_cnt <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      for (int t = 0; t < 16; t++) kern[t] <= '0;
    end else begin
      case (state)
        IDLE: if (start) tap_cnt <= '0;
        LOAD_K: begin
          if (k_valid) begin
            kern[tap_cnt] <= k_data;
            tap_cnt       <= tap_cnt + 4'd1;
            if (tap_cnt == 4'd15) begin
              row       <= '0;
              col       <= '0;
              fetch_cnt <= '0;
            end
          end
        end
        FETCH: fetch_cnt <= fetch_cnt + 4'd1;
        CONV: begin
          out_valid <= 1'b1;
          out_data  <= conv_result;
          out_row   <= row;
          out_col   <= col;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fetch_cnt <= '0;
            if (more_cols) begin
              col <= col + AW'(1);
            end else if (more_rows) begin
              col <= '0;
              row <= row + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read data returns one cycle after its strobe, so the write index trails fetch_cnt by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      for (int t = 0; t < 16; t++) win[t] <= '0;
    end else begin
      cap_valid <= (state == FETCH);
      cap_idx   <= fetch_cnt;
      if (cap_valid) win[cap_idx] <= mem_data;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign win_flat[g*lenOfInput +: lenOfInput]  = win[g];
    assign kern_flat[g*lenOfInput +: lenOfInput] = kern[g];
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Randomised self-checking bench for conv_window_sched with a pixel memory,
// a behavioural datapath and a frame-level reference model.
module tb_conv_window_sched;

  localparam int LI   = 8;
  localparam int LO   = 25;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int AW   = 6;
  localparam int NCOL = W - 3;
  localparam int NPOS = (H - 3) * (W - 3);

  logic              clk, rst, start, busy, done;
  logic              k_valid, k_ready, mem_rd, out_valid, out_ready;
  logic [LI-1:0]     k_data, mem_data;
  logic [AW-1:0]     mem_addr, out_row, out_col;
  logic [16*LI-1:0]  win_flat, kern_flat;
  logic [LO-1:0]     conv_result, out_data;

  int vectors = 0;
  int miscompares = 0;

  logic [LI-1:0] img [W*H];
  int            kref [16];
  int            q_data[$], q_row[$], q_col[$];
  int            done_pulses, done_gap;
  logic          busy_after_done;
  logic [31:0]   acc;

  conv_window_sched #(
    .lenOfInput(LI), .lenOfOutput(LO), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .win_flat(win_flat), .kern_flat(kern_flat), .conv_result(conv_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous pixel memory: data appears one cycle after the strobe
  initial mem_data = '0;
  always @(posedge clk) if (mem_rd) mem_data <= img[mem_addr];

  // Unsigned MAC datapath standing in for the real one
  always_comb begin
    acc = '0;
    for (int t = 0; t < 16; t++)
      acc = acc + 32'(win_flat[t*LI +: LI]) * 32'(kern_flat[t*LI +: LI]);
    conv_result = acc[LO-1:0];
  end

  function automatic int ref_conv(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        s += int'(img[(r + i) * W + c + j]) * kref[4*i + j];
    return s;
  endfunction

  function automatic logic [16*LI-1:0] pack_kernel();
    logic [16*LI-1:0] v;
    for (int t = 0; t < 16; t++) v[t*LI +: LI] = LI'(kref[t]);
    return v;
  endfunction

  task automatic set_image(input int kind);
    for (int a = 0; a < W*H; a++)
      img[a] = (kind == 0) ? LI'(a) : (kind == 1) ? 8'd255 : LI'($urandom);
  endtask

  task automatic set_kernel(input int kind);
    for (int t = 0; t < 16; t++)
      kref[t] = (kind == 0) ? ((t == 0) ? 1 : 0) : (kind == 1) ? 255 : int'($urandom_range(0, 255));
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Streams the 16 taps; returns at the negedge of the first FETCH cycle
  task automatic feed_taps(input bit gaps);
    int idx = 0;
    int cyc = 0;
    bit ph  = 1'b1;
    while (idx < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      k_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      k_data = k_valid ? LI'(kref[idx]) : LI'($urandom);
      if (k_valid && k_ready) idx++;
    end
    @(negedge clk);
    k_valid = 1'b0;
    if (idx < 16) begin
      vectors++; miscompares++;
      $display("[TB] FAIL kernel_load_timeout accepted=%0d required=16", idx);
    end
  endtask

  // Accepts results until done, recording them and the done pulse timing
  task automatic collect(input bit rand_ready);
    int cyc = 0;
    int last_acc = -100;
    bit seen = 1'b0;
    q_data.delete(); q_row.delete(); q_col.delete();
    done_pulses = 0; done_gap = -1; busy_after_done = 1'b1;
    while (!seen && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1; done_pulses++; done_gap = cyc - last_acc;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (out_valid && out_ready) begin
          q_data.push_back(int'(out_data));
          q_row.push_back(int'(out_row));
          q_col.push_back(int'(out_col));
          last_acc = cyc;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) busy_after_done = busy;
      if (done) done_pulses++;
    end
    out_ready = 1'b1;
    if (!seen) begin
      vectors++; miscompares++;
      $display("[TB] FAIL frame_done_timeout results=%0d required=%0d", q_data.size(), NPOS);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({busy, done, k_ready, mem_rd, out_valid} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got=%b want=00000", {busy, done, k_ready, mem_rd, out_valid});
    end
    vectors++;
    if ({out_data, out_row, out_col, mem_addr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got data=%0d row=%0d col=%0d addr=%0d want=0", out_data, out_row, out_col, mem_addr);
    end
    vectors++;
    if ({win_flat, kern_flat} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs got win=%h kern=%h want=0", win_flat, kern_flat);
    end
  endtask

  task automatic test_frames();
    int r, c, exp_v, lat;
    for (int p = 0; p < 4; p++) begin
      set_image(p < 2 ? p : 2);
      set_kernel(p < 2 ? p : 2);
      pulse_start();
      feed_taps(p == 3);
      vectors++;
      if (mem_rd !== 1'b1 || mem_addr !== '0) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_first_read got rd=%0b addr=%0d want rd=1 addr=0", p, mem_rd, mem_addr);
      end
      out_ready = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
      vectors++;
      if (lat != 18) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_latency got=%0d want=18", p, lat);
      end
      collect(p >= 2);
      vectors++;
      if (q_data.size() != NPOS) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_count got=%0d want=%0d", p, q_data.size(), NPOS);
      end
      for (int n = 0; n < q_data.size(); n++) begin
        r = n / NCOL; c = n % NCOL;
        exp_v = (p == 0) ? r * W + c : (p == 1) ? 1040400 : ref_conv(r, c);
        vectors++;
        if (q_data[n] != exp_v) begin
          miscompares++;
          $display("[TB] FAIL frame%0d_data[%0d] got=%0d want=%0d", p, n, q_data[n], exp_v);
        end
        vectors++;
        if (q_row[n] != r || q_col[n] != c) begin
          miscompares++;
          $display("[TB] FAIL frame%0d_coord[%0d] got=(%0d,%0d) want=(%0d,%0d)", p, n, q_row[n], q_col[n], r, c);
        end
      end
      vectors++;
      if (done_pulses != 1 || done_gap != 1 || busy_after_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL frame%0d_done got pulses=%0d gap=%0d busy=%0b want 1/1/0", p, done_pulses, done_gap, busy_after_done);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int cyc = 0;
    logic [LO-1:0] held;
    set_image(2); set_kernel(2);
    pulse_start();
    feed_taps(1'b0);
    out_ready = 1'b1;
    while (n < 3 && cyc < 200) begin @(negedge clk); cyc++; if (out_valid) n++; end
    @(negedge clk);
    out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    held = out_data;
    vectors++;
    if (!out_valid || held !== LO'(ref_conv(0, 3))) begin
      miscompares++;
      $display("[TB] FAIL bp_result3 got valid=%0b data=%0d want valid=1 data=%0d", out_valid, held, ref_conv(0, 3));
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== held || mem_rd !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d] got valid=%0b data=%0d rd=%0b want 1/%0d/0", k, out_valid, out_data, mem_rd, held);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== AW'(4)) begin
      miscompares++;
      $display("[TB] FAIL bp_release got valid=%0b rd=%0b addr=%0d want 0/1/4", out_valid, mem_rd, mem_addr);
    end
    collect(1'b0);
    vectors++;
    if (q_data.size() != NPOS - 4 || done_pulses != 1) begin
      miscompares++;
      $display("[TB] FAIL bp_rest got count=%0d pulses=%0d want %0d/1", q_data.size(), done_pulses, NPOS - 4);
    end
    for (int m = 0; m < q_data.size(); m++) begin
      vectors++;
      if (q_data[m] != ref_conv((m + 4) / NCOL, (m + 4) % NCOL)) begin
        miscompares++;
        $display("[TB] FAIL bp_data[%0d] got=%0d want=%0d", m + 4, q_data[m], ref_conv((m + 4) / NCOL, (m + 4) % NCOL));
      end
    end
  endtask

  task automatic test_kernel_gaps();
    logic [16*LI-1:0] exp_k;
    set_image(2); set_kernel(2);
    exp_k = pack_kernel();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      k_valid = 1'b1; k_data = LI'($urandom);
      vectors++;
      if (k_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL kready_idle got=%0b want=0", k_ready);
      end
    end
    k_valid = 1'b0;
    pulse_start();
    feed_taps(1'b1);
    vectors++;
    if (kern_flat !== exp_k) begin
      miscompares++;
      $display("[TB] FAIL kernel_gaps got=%h want=%h", kern_flat, exp_k);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      k_valid = 1'b1; k_data = LI'($urandom);
      vectors++;
      if (k_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL kready_fetch got=%0b want=0", k_ready);
      end
    end
    @(negedge clk);
    k_valid = 1'b0;
    vectors++;
    if (kern_flat !== exp_k) begin
      miscompares++;
      $display("[TB] FAIL kernel_after_fetch_pulses got=%h want=%h", kern_flat, exp_k);
    end
    collect(1'b0);
    vectors++;
    if (q_data.size() != NPOS) begin
      miscompares++;
      $display("[TB] FAIL gaps_count got=%0d want=%0d", q_data.size(), NPOS);
    end
    for (int n = 0; n < q_data.size(); n++) begin
      vectors++;
      if (q_data[n] != ref_conv(n / NCOL, n % NCOL)) begin
        miscompares++;
        $display("[TB] FAIL gaps_data[%0d] got=%0d want=%0d", n, q_data[n], ref_conv(n / NCOL, n % NCOL));
      end
    end
  endtask

  task automatic test_start_held();
    set_image(2); set_kernel(2);
    @(negedge clk);
    start = 1'b1;
    feed_taps(1'b0);
    collect(1'b1);
    vectors++;
    if (q_data.size() != NPOS || done_pulses != 1 || busy_after_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL held_frame got count=%0d pulses=%0d busy=%0b want %0d/1/0", q_data.size(), done_pulses, busy_after_done, NPOS);
    end
    for (int n = 0; n < q_data.size(); n++) begin
      vectors++;
      if (q_data[n] != ref_conv(n / NCOL, n % NCOL)) begin
        miscompares++;
        $display("[TB] FAIL held_data[%0d] got=%0d want=%0d", n, q_data[n], ref_conv(n / NCOL, n % NCOL));
      end
    end
    vectors++;
    if (k_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL held_restart got kready=%0b busy=%0b want 1/1", k_ready, busy);
    end
    start = 1'b0;
    set_kernel(2);
    feed_taps(1'b0);
    vectors++;
    if (mem_rd !== 1'b1 || mem_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL held_first_read got rd=%0b addr=%0d want rd=1 addr=0", mem_rd, mem_addr);
    end
    collect(1'b0);
    vectors++;
    if (q_data.size() != NPOS || q_data[NPOS-1] != ref_conv(H - 4, W - 4)) begin
      miscompares++;
      $display("[TB] FAIL held_second_frame got count=%0d want=%0d", q_data.size(), NPOS);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    int bad = 0;
    set_image(2); set_kernel(2);
    pulse_start();
    feed_taps(1'b0);
    out_ready = 1'b1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_rd !== 1'b1 || mem_addr !== AW'(2)) begin
      miscompares++;
      $display("[TB] FAIL rst_pre_fetch got rd=%0b addr=%0d want rd=1 addr=2", mem_rd, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, out_valid, mem_rd, done, k_ready} !== 5'b0 || kern_flat !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_abort got ctrl=%b kern=%h want 00000/0", {busy, out_valid, mem_rd, done, k_ready}, kern_flat);
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL rst_quiet got busy_or_done_cycles=%0d want=0", bad);
    end
    set_kernel(2);
    pulse_start();
    feed_taps(1'b0);
    vectors++;
    if (kern_flat !== pack_kernel()) begin
      miscompares++;
      $display("[TB] FAIL rst_reload got=%h want=%h", kern_flat, pack_kernel());
    end
    collect(1'b0);
    vectors++;
    if (q_data.size() != NPOS) begin
      miscompares++;
      $display("[TB] FAIL rst_frame_count got=%0d want=%0d", q_data.size(), NPOS);
    end
    for (int n = 0; n < q_data.size(); n++) begin
      vectors++;
      if (q_data[n] != ref_conv(n / NCOL, n % NCOL)) begin
        miscompares++;
        $display("[TB] FAIL rst_frame_data[%0d] got=%0d want=%0d", n, q_data[n], ref_conv(n / NCOL, n % NCOL));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_valid = 1'b0; k_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_frames();
    test_backpressure();
    test_kernel_gaps();
    test_start_held();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
